// File: rtl/st_reg_ram_clr.sv
// st_reg_ram_clr
// Single-clock envelope-state register RAM, one DATA_WIDTH-bit word per
// {voice, env} slot. After reset, and whenever clr_req is seen while idle,
// a sweep writes zero to every slot. busy is high for the whole sweep.
// User writes are ignored during the sweep and q reads zero.
//
// Optional feature macro: ST_REG_RAM_BYPASS_EN
//   defined   -> write-first: on a write/read collision to the same slot,
//                q takes the new write data on that edge.
//   undefined -> read-first: on a collision q returns the old contents,
//                and the new data appears on the next read.
//
// Valid/ready note: reads have no handshake. q is valid one cycle after
// read_address whenever busy was low on that edge. Writes are accepted on
// any edge where busy is low and the address is below VOICES*V_ENVS.
module st_reg_ram_clr #(
    parameter int VOICES     = 8,
    parameter int V_ENVS     = 8,
    parameter int V_WIDTH    = 3,
    parameter int E_WIDTH    = 3,
    parameter int DATA_WIDTH = 106
) (
    input  logic                         sCLK_XVXENVS,
    input  logic                         reset,
    input  logic                         clr_req,
    input  logic                         we,
    input  logic [V_WIDTH+E_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]        d,
    input  logic [V_WIDTH+E_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         busy
);

    localparam int AW     = V_WIDTH + E_WIDTH;
    localparam int DEPTH  = VOICES * V_ENVS;
    localparam int LAST_I = DEPTH - 1;

    // Last sweep address, and DEPTH held one bit wider so that a full
    // 2^AW-deep memory still compares correctly.
    localparam logic [AW-1:0] LAST    = LAST_I[AW-1:0];
    localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];

    // The address fields must be able to reach every slot.
    generate
        if ((1 << AW) < DEPTH) begin : g_depth_check
            $error("st_reg_ram_clr: V_WIDTH+E_WIDTH too small for VOICES*V_ENVS");
        end
    endgenerate

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                state;
    logic [AW-1:0]         clr_cnt;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    assign wr_in_range = ({1'b0, write_address} < DEPTH_W);
    assign rd_in_range = ({1'b0, read_address}  < DEPTH_W);

    // Single write port shared by the sweep and the user; sweep wins while clearing.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = write_address;
        mem_din  = d;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt;
                mem_din  = '0;
            end else if (we && wr_in_range) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array: no reset, so it maps onto block RAM; zeroing is the sweep's job.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Sweep/idle controller; busy is simply a registered view of being in CLEAR.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        // Hold the counter here rather than letting it roll over.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

`ifdef ST_REG_RAM_BYPASS_EN
    logic collide;

    // Same in-range slot written and read on one edge while idle.
    assign collide = (state == IDLE) && we && wr_in_range &&
                     (write_address == read_address);

    // Registered read port, write-first on a collision.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset || state == CLEAR) begin
            q <= '0;
        end else if (collide) begin
            q <= d;
        end else if (rd_in_range) begin
            q <= mem[read_address];
        end else begin
            q <= '0;
        end
    end
`else
    // Registered read port, read-first: a colliding write shows up on the next read.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset || state == CLEAR) begin
            q <= '0;
        end else if (rd_in_range) begin
            q <= mem[read_address];
        end else begin
            q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_st_reg_ram_clr.sv
// tb_st_reg_ram_clr
// Bench for st_reg_ram_clr: a default 64-slot instance and a 48-slot
// instance (VOICES=6) for the out-of-range rules.
// Honours ST_REG_RAM_BYPASS_EN for the collision expectations.
module tb_st_reg_ram_clr;

    localparam int DW = 106;
    localparam int AW = 6;
    localparam int DEPTH = 64;
`ifdef ST_REG_RAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clr_req, we;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] d, q;
    logic          busy;

    logic          r48, c48, we48;
    logic [AW-1:0] wa48, ra48;
    logic [DW-1:0] d48, q48;
    logic          busy48;

    st_reg_ram_clr dut (
        .sCLK_XVXENVS (clk),
        .reset        (reset),
        .clr_req      (clr_req),
        .we           (we),
        .write_address(wa),
        .d            (d),
        .read_address (ra),
        .q            (q),
        .busy         (busy)
    );

    st_reg_ram_clr #(.VOICES(6), .V_ENVS(8)) dut48 (
        .sCLK_XVXENVS (clk),
        .reset        (r48),
        .clr_req      (c48),
        .we           (we48),
        .write_address(wa48),
        .d            (d48),
        .read_address (ra48),
        .q            (q48),
        .busy         (busy48)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_m [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ones;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_q;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy drops; q must stay 0 throughout and on the first
    // idle cycle. With junk=1 random writes and clr_req pulses are thrown at
    // the sweep, all of which must be ignored.
    task automatic wait_sweep(input string name, input int expected, input bit junk);
        int n = 0;
        int qbad = 0;
        while (busy === 1'b1 && n < 200) begin
            if (junk) begin
                we      = 1'b1;
                wa      = AW'($urandom_range(0, DEPTH - 1));
                d       = DW'(32'h77);
                clr_req = ($urandom_range(0, 7) == 0);
            end
            tick();
            n++;
            if (q !== '0) qbad++;
        end
        we = 1'b0;
        clr_req = 1'b0;
        chk({name, "_len"}, DW'(n), DW'(expected));
        chk({name, "_q0"}, DW'(qbad), '0);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i);
            tick();
            chk($sformatf("%s_slot%0d", name, i), q, '0);
        end
    endtask

    task automatic fill_all(input logic [DW-1:0] val);
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1;
            wa = AW'(i);
            d  = val;
            tick();
            mem_m[i] = val;
        end
        we = 1'b0;
    endtask

    // One idle-mode cycle checked against the array model.
    task automatic do_op(input string name, input logic w, input logic [AW-1:0] a_w,
                         input logic [DW-1:0] dat, input logic [AW-1:0] a_r);
        we = w; wa = a_w; d = dat; ra = a_r;
        if (BYP && w && a_w == a_r) exp_q.push_back(dat);
        else                        exp_q.push_back(mem_m[a_r]);
        tick();
        chk(name, q, exp_q.pop_front());
        if (w) mem_m[a_w] = dat;
        we = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a_w, input logic [DW-1:0] dat,
                                input logic [AW-1:0] a_r, input logic [DW-1:0] e);
        vec_t v;
        v.we = w; v.wa = a_w; v.d = dat; v.ra = a_r; v.exp_q = e;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n48;
        ones = '1;
        reset = 1'b1; clr_req = 1'b0; we = 1'b0; wa = '0; ra = '0; d = '0;
        r48 = 1'b1; c48 = 1'b0; we48 = 1'b0; wa48 = '0; ra48 = '0; d48 = '0;

        // Reset state, then the power-up sweep.
        repeat (3) tick();
        chk("rst_busy", DW'(busy), DW'(1));
        chk("rst_q", q, '0);
        reset = 1'b0;
        wait_sweep("sweep_init", DEPTH, 1'b0);

        // Preload 0x3FF, then a fresh reset must wipe it.
        fill_all(DW'(32'h3FF));
        ra = 6'd17;
        tick();
        chk("preload", q, DW'(32'h3FF));
        reset = 1'b1;
        repeat (3) tick();
        chk("rst2_busy", DW'(busy), DW'(1));
        reset = 1'b0;
        wait_sweep("sweep_rst2", DEPTH, 1'b0);
        read_all_zero("rst2");

        // Table vectors from an all-zero memory.
        vecs[0] = mk(1'b1, 6'h2A, DW'(64'h123456789), 6'h00, '0);
        vecs[1] = mk(1'b0, 6'h00, '0,                 6'h2A, DW'(64'h123456789));
        vecs[2] = mk(1'b1, 6'h05, DW'(32'h111),       6'h2A, DW'(64'h123456789));
        vecs[3] = mk(1'b1, 6'h05, DW'(32'hABC),       6'h05, BYP ? DW'(32'hABC) : DW'(32'h111));
        vecs[4] = mk(1'b0, 6'h00, '0,                 6'h05, DW'(32'hABC));
        vecs[5] = mk(1'b1, 6'h3F, ones,               6'h3F, BYP ? ones : '0);
        vecs[6] = mk(1'b0, 6'h00, '0,                 6'h3F, ones);
        vecs[7] = mk(1'b1, 6'h00, DW'(32'h3FF),       6'h05, DW'(32'hABC));
        vecs[8] = mk(1'b0, 6'h00, '0,                 6'h00, DW'(32'h3FF));
        for (int i = 0; i < 9; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; d = vecs[i].d; ra = vecs[i].ra;
            tick();
            chk($sformatf("vec%0d", i), q, vecs[i].exp_q);
            if (vecs[i].we) mem_m[vecs[i].wa] = vecs[i].d;
        end
        we = 1'b0;

        // Random idle traffic with frequent same-slot collisions.
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a_w, a_r;
            logic [DW-1:0] dat;
            a_w = AW'($urandom_range(0, DEPTH - 1));
            a_r = ($urandom_range(0, 3) == 0) ? a_w : AW'($urandom_range(0, DEPTH - 1));
            dat = {DW'($urandom), 32'($urandom), 32'($urandom)};
            do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a_w, dat, a_r);
        end

        // clr_req in idle, with a write in the same cycle and junk during the sweep.
        fill_all(DW'(32'h5));
        we = 1'b1; wa = 6'd3; d = DW'(32'h7); clr_req = 1'b1;
        tick();
        chk("clr_busy_rise", DW'(busy), DW'(1));
        we = 1'b0; clr_req = 1'b0;
        wait_sweep("sweep_clr", DEPTH, 1'b1);
        read_all_zero("clr");

        // Reset landing at sweep cycle 30 restarts a full-length sweep.
        do_op("pre_rst30", 1'b1, 6'd9, DW'(32'h99), 6'd0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        wait_sweep("sweep_rst30", DEPTH, 1'b0);
        ra = 6'd9;
        tick();
        chk("rst30_slot9", q, '0);

        // 48-slot instance: sweep length and out-of-range rules.
        tick();
        r48 = 1'b0;
        n48 = 0;
        while (busy48 === 1'b1 && n48 < 200) begin
            tick();
            n48++;
        end
        chk("d48_sweep_len", DW'(n48), DW'(48));
        we48 = 1'b1; wa48 = 6'd50; d48 = DW'(32'hDEAD); ra48 = 6'd50;
        tick();
        chk("d48_oor_collide", q48, '0);
        wa48 = 6'd47; d48 = DW'(32'h99); ra48 = 6'd47;
        tick();
        chk("d48_last_collide", q48, BYP ? DW'(32'h99) : '0);
        we48 = 1'b0; ra48 = 6'd47;
        tick();
        chk("d48_last_read", q48, DW'(32'h99));
        ra48 = 6'd50;
        tick();
        chk("d48_oor_read", q48, '0);
        ra48 = 6'd2;
        tick();
        chk("d48_alias_slot2", q48, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
